vga_line_fetch: RTL
===================

// Module: vga_line_fetch
// PURPOSE
//  Pixel source for the 800x480 VGA timing generator. It prefetches the next visible line from a
//  3-bit-per-pixel framebuffer memory into a ping-pong line buffer. It then drives registered
//  R/G/B, aligned to the generator's hor/ver counters. It sits between the framebuffer
//  arbiter (upstream) and the VGA pin/timing stage (downstream).
// PARAMETERS
//  H_ACTIVE   800  visible pixels per line
//  H_TOTAL    976  pixel clocks per line (counter wraps at H_TOTAL-1)
//  V_ACTIVE   480  visible lines per frame
//  V_TOTAL    528  lines per frame (counter wraps at V_TOTAL-1)
//  PIX_PER_W  8    pixels per memory word, 3 bits each {r,g,b}, pixel 0 in bits [2:0]
//  ADDR_W     16   memory word address width
// PORTS
//  CLOCK_PIXEL   in   1             pixel clock, all logic on rising edge
//  RESET         in   1             synchronous, active-high
//  hor_count     in   11            horizontal counter from timing generator
//  ver_count     in   10            vertical counter from timing generator
//  mem_rd_req    out  1             read request, held until mem_rd_ack
//  mem_addr      out  ADDR_W        word address, stable while mem_rd_req=1
//  mem_rd_ack    in   1             one-cycle strobe: mem_rdata valid this cycle
//  mem_rdata     in   3*PIX_PER_W   read data
//  VGA_RED/GREEN/BLUE out 1 each    registered pixel colour
//  underrun      out  1             sticky: a line fetch did not complete in time
// BEHAVIOUR
//  Reset (sync): mem_rd_req=0, mem_addr=0, RGB=0, underrun=0, FSM=IDLE, both buffer-valid bits=0.
//   Buffer RAM contents are not cleared.
//  Words per line: WPL = H_ACTIVE/PIX_PER_W = 100. Address = line*WPL + word.
//  Trigger: at hor_count==0, the FSM starts a fetch of the target line T into the non-display buffer.
//   T = ver_count+1 when ver_count < V_ACTIVE-1. T = 0 when ver_count == V_TOTAL-1.
//   Otherwise there is no fetch.
//  FSM states:
//   IDLE  -> REQ on trigger. word=0; the target buffer's valid bit is cleared.
//   REQ   mem_rd_req=1. On ack: write the word to the buffer. If word==WPL-1 go DONE,
//         else word+1 and stay in REQ. mem_rd_req stays high across back-to-back words.
//   DONE  set the target buffer's valid bit; -> IDLE.
//  Deadline: if hor_count==H_TOTAL-1 while in REQ:
//   underrun<=1; the FSM returns to IDLE; mem_rd_req drops the next cycle.
//   The target buffer's valid bit stays 0.
//   An ack arriving in that same cycle is discarded.
//  Buffer swap at hor_count==H_TOTAL-1: the display buffer index toggles when the next line is
//   visible, so the line fetched during line v is displayed on line v+1.
//  Output: 1-cycle latency. RGB on cycle n+1 reflects hor/ver_count sampled on cycle n.
//   RGB = pixel[hor_count] when hor_count<H_ACTIVE, ver_count<V_ACTIVE and the display buffer is valid.
//   Otherwise RGB=0 (porches, sync, and invalid/underrun lines).
//  Counter values >= H_TOTAL or >= V_TOTAL are treated as blanking and start no fetch.
//  underrun clears only on RESET.
//  RESET mid-fetch: the request drops on the next cycle and no buffer is marked valid.
//   The first valid line appears only after a complete fetch.
// TESTING
//  1. Ack every cycle, memory word k = k[23:0] pattern.
//     -> line 5, pixel 17 shows bits of word 502 [5:3]; mem_addr runs 500..599 during line 4.
//  2. Ack latency 3 cycles. -> 100 words in 400 < 976 cycles, no underrun; every line matches memory.
//  3. Ack latency 10 cycles -> underrun=1 on the first line.
//     The affected line outputs RGB=0; the following frame recovers once latency returns to 1.
//  4. ver_count=527, hor_count=0 -> fetch from mem_addr 0. ver 480..526 -> no mem_rd_req.
//  5. Blanking: hor_count 800..975 or ver_count 480..527 -> RGB=0 on the following cycle.
//  6. RESET asserted while in REQ at word 40.
//     -> next cycle: mem_rd_req=0, underrun=0. RGB stays 0 until the first complete fetch.

Source files
------------

// File: rtl/vga_line_fetch.sv
// vga_line_fetch: ping-pong line prefetch from a 3bpp framebuffer (mem_rd_req/mem_addr/mem_rd_ack/mem_rdata) to registered VGA_RED/GREEN/BLUE aligned to hor_count/ver_count, sticky underrun
module vga_line_fetch #(
  parameter int H_ACTIVE  = 800,
  parameter int H_TOTAL   = 976,
  parameter int V_ACTIVE  = 480,
  parameter int V_TOTAL   = 528,
  parameter int PIX_PER_W = 8,
  parameter int ADDR_W    = 16
) (
  input  logic                   CLOCK_PIXEL,
  input  logic                   RESET,
  input  logic [10:0]            hor_count,
  input  logic [9:0]             ver_count,
  output logic                   mem_rd_req,
  output logic [ADDR_W-1:0]      mem_addr,
  input  logic                   mem_rd_ack,
  input  logic [3*PIX_PER_W-1:0] mem_rdata,
  output logic                   VGA_RED,
  output logic                   VGA_GREEN,
  output logic                   VGA_BLUE,
  output logic                   underrun
);
  localparam int WPL = H_ACTIVE / PIX_PER_W;
  localparam int WW  = $clog2(WPL);
  localparam int SW  = $clog2(3 * PIX_PER_W);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, state_nx;
  logic [WW-1:0] word, rd_word;
  logic [SW-1:0] rd_sh;
  logic [9:0] tgt_line;
  logic [1:0] valid;
  logic disp, tgt, fetch_line, trig, deadline, take, active;
  logic [3*PIX_PER_W-1:0] line_buf [2][WPL];
  logic [3*PIX_PER_W-1:0] rd_data;
  assign fetch_line = (ver_count < 10'(V_ACTIVE - 1)) || (ver_count == 10'(V_TOTAL - 1));
  assign trig       = (state == IDLE) && (hor_count == 11'd0) && fetch_line;
  assign deadline   = hor_count == 11'(H_TOTAL - 1);
  assign take       = (state == REQ) && mem_rd_ack && !deadline;
  assign tgt_line   = (ver_count == 10'(V_TOTAL - 1)) ? 10'd0 : ver_count + 10'd1;
  assign mem_rd_req = state == REQ;
  assign rd_word    = WW'(hor_count / 11'(PIX_PER_W));
  assign rd_sh      = SW'(hor_count % 11'(PIX_PER_W)) * SW'(3);
  assign rd_data    = line_buf[disp][rd_word];
  assign active     = (hor_count < 11'(H_ACTIVE)) && (ver_count < 10'(V_ACTIVE)) && valid[disp];
  always_comb begin
    state_nx = (state == DONE) ? IDLE
             : (state == REQ)  ? (deadline ? IDLE : (take && word == WW'(WPL - 1)) ? DONE : REQ)
             : (trig ? REQ : IDLE);
  end
  always_ff @(posedge CLOCK_PIXEL) begin
    if (RESET) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge CLOCK_PIXEL) begin
    if (RESET) begin
      mem_addr <= '0;
      valid    <= '0;
      disp     <= 1'b0;
      tgt      <= 1'b0;
      word     <= '0;
      underrun <= 1'b0;
      {VGA_RED, VGA_GREEN, VGA_BLUE} <= 3'b0;
    end else begin
      if (trig) begin
        word        <= '0;
        tgt         <= ~disp;
        valid[~disp] <= 1'b0;
        mem_addr    <= ADDR_W'(32'(tgt_line) * WPL);
      end
      if (take) begin
        word     <= word + 1'b1;
        mem_addr <= mem_addr + 1'b1;
      end
      if (state == REQ && deadline) underrun <= 1'b1;
      if (state == DONE) valid[tgt] <= 1'b1;
      if (deadline && fetch_line) disp <= ~disp;
      {VGA_RED, VGA_GREEN, VGA_BLUE} <= active ? rd_data[rd_sh +: 3] : 3'b0;
    end
  end
  always_ff @(posedge CLOCK_PIXEL) begin
    if (take) line_buf[tgt][word] <= mem_rdata;
  end
endmodule
